lane_regfile: RTL and testbench
===============================

# lane_regfile

Parametrised general-purpose register file for the 16-bit pipelined CPU datapath, generalising the current 8-entry, nibble-writable file. It provides configurable width, depth and write-lane granularity, plus two operand read ports and one store-data read port. It adds optional write-to-read bypass and two self-updating special registers: a post-incrementing address pointer and a saturating loop counter with a zero flag. It sits between decode/writeback and the ALU/memory stage.

## Interface
Parameters:
- `WIDTH`, 16, register width in bits
- `DEPTH`, 8, number of registers (2..256)
- `LANE_W`, 4, write-lane width; `WIDTH % LANE_W == 0`; `LANES = WIDTH/LANE_W`
- `ADR_IDX`, 4, index of the address-pointer register
- `CNT_IDX`, 7, index of the loop-counter register
- `ADR_STEP`, 1, post-increment amount
- `BYPASS`, 1, 1 = reads see same-cycle write data

Ports:
- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  synchronous active-low reset
- `wr_en`  in  1  write strobe
- `wr_addr`  in  AW  write index (`AW = $clog2(DEPTH)`)
- `wr_data`  in  WIDTH  write data, lane-aligned
- `wr_lane_mask`  in  LANES  lanes to update; all-ones = full write
- `rd_addr0`, `rd_addr1`  in  AW  operand read indices
- `rd0_imm`  in  1  `rd_data0` = zero-extended `rd_addr0` (immediate)
- `rd1_zero`  in  1  force `rd_data1` = 0 (move)
- `rd_data0`, `rd_data1`  out  WIDTH  operand data
- `st_addr`  in  AW  store-data read index
- `st_data`  out  WIDTH  store data
- `adr_inc`  in  1  post-increment register `ADR_IDX` by `ADR_STEP`
- `cnt_dec`  in  1  decrement register `CNT_IDX`, saturating at 0
- `addr_out`  out  WIDTH  current value of register `ADR_IDX`
- `cnt_zero`  out  1  register `CNT_IDX` == 0

## Operation
- Reset (`rst_n`=0 at an edge): every register is cleared to 0. Reset overrides `wr_en`, `adr_inc` and `cnt_dec`. Resulting outputs are `addr_out`=0 and `cnt_zero`=1. `rd_data*` and `st_data` read 0 unless `rd0_imm` is set.
- Write: on an edge with `wr_en`=1 and `wr_addr < DEPTH`, each lane i with `wr_lane_mask[i]`=1 takes `wr_data[i*LANE_W +: LANE_W]`. Unmasked lanes hold their value. A mask of 0 writes nothing.
- Out-of-range index (`>= DEPTH`): writes are ignored and reads return 0.
- Read priority for `rd_data0`: `rd0_imm`, then bypass, then array.
- Read priority for `rd_data1`: `rd1_zero`, then bypass, then array.
- `st_data` follows the same bypass rule as the operand ports.
- Bypass (`BYPASS`=1): when `wr_en`=1 and the read index equals `wr_addr`, the port returns the lane-merged value, i.e. the value the register will hold after the edge. With `BYPASS`=0 the port returns the pre-edge value.
- `adr_inc`: `adr <= adr + ADR_STEP`, modulo 2^WIDTH, wrapping at 0xFFFF→0x0000 for the default step.
- `cnt_dec`: `cnt <= cnt - 1` if `cnt != 0`; otherwise `cnt` holds at 0.
- Same-cycle collision: an explicit write to `ADR_IDX` or `CNT_IDX` (nonzero mask) takes precedence. The inc/dec is dropped entirely, including for unmasked lanes.
- `adr_inc` and `cnt_dec` may be asserted together; they are independent.
- Bypass reflects only explicit writes, never inc/dec results.

## Timing
- All state updates at the rising edge of `clk`; write-to-array latency is 1 cycle.
- `rd_data*`, `st_data`, `addr_out` and `cnt_zero` are combinational from the array and the current inputs. There is no internal read latency.
- With `BYPASS`=0, a read of a register written in cycle N returns the new value from cycle N+1.
- `cnt_zero` asserts in the cycle after the decrement that reaches 0.
- There are no handshakes; inputs are sampled every edge.

## Structure
- Package `regfile_pkg`:
  - default index constants (`ADR_IDX`=4, `CNT_IDX`=7);
  - a `lanes(width, lane_w)` function;
  - elaboration checks for `WIDTH % LANE_W`, `ADR_IDX < DEPTH` and `CNT_IDX < DEPTH`, with `ADR_IDX != CNT_IDX`.
- Sub-module `lane_merge`: purely combinational `(old, new, mask) -> merged`. It is instantiated once and shared by the array write path and the bypass path, so the two paths cannot diverge.

## Test plan
- Reset, then full write 0xBEEF to r2; next cycle read r2 → 0xBEEF. Assert `rst_n`=0 together with `wr_en` → r2=0, `cnt_zero`=1.
- r1=0x1234, then write 0x00A0 with mask 4'b0010 → r1=0x12A4; mask 0 → r1 unchanged.
- With `BYPASS`=1, write 0x5555 to r3 while reading r3 on both ports and `st_addr` → all return 0x5555 in the same cycle. With `BYPASS`=0 → old value, then 0x5555 next cycle.
- adr=0xFFFF with `adr_inc` → 0x0000. Same cycle `adr_inc` plus full write 0x0100 to `ADR_IDX` → 0x0100, increment dropped.
- cnt=2, `cnt_dec` for 3 cycles → 1, 0, 0; `cnt_zero` rises after the second edge and stays high.
- `rd0_imm`=1, `rd_addr0`=5 → `rd_data0`=0x0005. `rd1_zero`=1 → `rd_data1`=0. With `DEPTH`=6, write to index 7 is ignored and a read of 7 returns 0.

Source files
------------

// File: rtl/lane_regfile_pkg.sv
`default_nettype none
// regfile_pkg: shared index defaults, lane-count helper and configuration checks for lane_regfile.
// Rev 1.0
package regfile_pkg;

  localparam int DEF_ADR_IDX = 4;
  localparam int DEF_CNT_IDX = 7;

  function automatic int lanes(input int width, input int lane_w);
    return width / lane_w;
  endfunction

  function automatic bit cfg_ok(input int width, input int lane_w, input int depth,
                                input int adr_idx, input int cnt_idx);
    return (lane_w > 0) && (width % lane_w == 0) &&
           (depth >= 2) && (depth <= 256) &&
           (adr_idx >= 0) && (adr_idx < depth) &&
           (cnt_idx >= 0) && (cnt_idx < depth) &&
           (adr_idx != cnt_idx);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lane_merge.sv
`default_nettype none
// lane_merge: per-lane select of new data over old data under a lane mask.
// Rev 1.0
module lane_merge
  import regfile_pkg::*;
#(
  parameter  int WIDTH  = 16,
  parameter  int LANE_W = 4,
  localparam int LANES  = lanes(WIDTH, LANE_W)
) (
  input  logic [WIDTH-1:0] old_val,
  input  logic [WIDTH-1:0] new_val,
  input  logic [LANES-1:0] mask,
  output logic [WIDTH-1:0] merged
);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign merged[i*LANE_W +: LANE_W] = mask[i] ? new_val[i*LANE_W +: LANE_W]
                                                : old_val[i*LANE_W +: LANE_W];
  end

endmodule
`default_nettype wire

// File: rtl/lane_regfile.sv
`default_nettype none
// lane_regfile: lane-writable register file with bypass, post-incrementing address pointer and loop counter.
// Rev 1.0
module lane_regfile
  import regfile_pkg::*;
#(
  parameter  int WIDTH    = 16,
  parameter  int DEPTH    = 8,
  parameter  int LANE_W   = 4,
  parameter  int ADR_IDX  = DEF_ADR_IDX,
  parameter  int CNT_IDX  = DEF_CNT_IDX,
  parameter  int ADR_STEP = 1,
  parameter  int BYPASS   = 1,
  localparam int LANES    = lanes(WIDTH, LANE_W),
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [LANES-1:0] wr_lane_mask,
  input  logic [AW-1:0]    rd_addr0,
  input  logic [AW-1:0]    rd_addr1,
  input  logic             rd0_imm,
  input  logic             rd1_zero,
  output logic [WIDTH-1:0] rd_data0,
  output logic [WIDTH-1:0] rd_data1,
  input  logic [AW-1:0]    st_addr,
  output logic [WIDTH-1:0] st_data,
  input  logic             adr_inc,
  input  logic             cnt_dec,
  output logic [WIDTH-1:0] addr_out,
  output logic             cnt_zero
);

  if (!cfg_ok(WIDTH, LANE_W, DEPTH, ADR_IDX, CNT_IDX)) begin : g_cfg_check
    $error("lane_regfile: invalid WIDTH/LANE_W/DEPTH/ADR_IDX/CNT_IDX combination");
  end

  logic [DEPTH-1:0][WIDTH-1:0] regs_q, regs_d;
  logic             wr_in_range;
  logic             wr_commit;
  logic [WIDTH-1:0] wr_old;
  logic [WIDTH-1:0] wr_merged;

  assign wr_in_range = int'(wr_addr) < DEPTH;
  assign wr_old      = wr_in_range ? regs_q[wr_addr] : '0;
  assign wr_commit   = wr_en && wr_in_range && (|wr_lane_mask);

  // Single merge instance feeds both the array update and the bypass path.
  lane_merge #(
    .WIDTH  (WIDTH),
    .LANE_W (LANE_W)
  ) u_merge (
    .old_val (wr_old),
    .new_val (wr_data),
    .mask    (wr_lane_mask),
    .merged  (wr_merged)
  );

  // Explicit writes are applied last so they override inc/dec on the same register.
  always_comb begin
    regs_d = regs_q;
    if (adr_inc) begin
      regs_d[ADR_IDX] = regs_q[ADR_IDX] + WIDTH'(ADR_STEP);
    end
    if (cnt_dec && (regs_q[CNT_IDX] != '0)) begin
      regs_d[CNT_IDX] = regs_q[CNT_IDX] - WIDTH'(1);
    end
    if (wr_commit) begin
      regs_d[wr_addr] = wr_merged;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  function automatic logic [WIDTH-1:0] read_reg(
    input logic [AW-1:0]                 addr,
    input logic [DEPTH-1:0][WIDTH-1:0]   regs,
    input logic                          wen,
    input logic [AW-1:0]                 waddr,
    input logic [WIDTH-1:0]              merged
  );
    if (int'(addr) >= DEPTH) begin
      return '0;
    end
    if ((BYPASS != 0) && wen && (addr == waddr)) begin
      return merged;
    end
    return regs[addr];
  endfunction

  assign rd_data0 = rd0_imm  ? WIDTH'(rd_addr0)
                             : read_reg(rd_addr0, regs_q, wr_en, wr_addr, wr_merged);
  assign rd_data1 = rd1_zero ? '0
                             : read_reg(rd_addr1, regs_q, wr_en, wr_addr, wr_merged);
  assign st_data  = read_reg(st_addr, regs_q, wr_en, wr_addr, wr_merged);
  assign addr_out = regs_q[ADR_IDX];
  assign cnt_zero = (regs_q[CNT_IDX] == '0);

endmodule
`default_nettype wire

// File: tb/tb_lane_regfile.sv
`default_nettype none
// tb_lane_regfile: directed and randomized checks of three lane_regfile configurations against an array model.
module tb_lane_regfile;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic [3:0]  wr_lane_mask;
  logic [2:0]  rd_addr0, rd_addr1, st_addr;
  logic        rd0_imm, rd1_zero, adr_inc, cnt_dec;

  logic [15:0] rd0_o [3];
  logic [15:0] rd1_o [3];
  logic [15:0] st_o  [3];
  logic [15:0] adr_o [3];
  logic        cz_o  [3];

  int total = 0;
  int bad   = 0;

  // Configurations: 0 = defaults, 1 = no bypass, 2 = depth 6 with counter at index 5.
  int depth_c [3] = '{8, 8, 6};
  int adr_c   [3] = '{4, 4, 4};
  int cnt_c   [3] = '{7, 7, 5};
  int byp_c   [3] = '{1, 0, 1};

  logic [15:0] mdl [3][8];

  always #5 clk = ~clk;

  lane_regfile #(.WIDTH(16), .DEPTH(8), .LANE_W(4), .ADR_IDX(4), .CNT_IDX(7),
                 .ADR_STEP(1), .BYPASS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_lane_mask(wr_lane_mask), .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
    .rd0_imm(rd0_imm), .rd1_zero(rd1_zero), .rd_data0(rd0_o[0]), .rd_data1(rd1_o[0]),
    .st_addr(st_addr), .st_data(st_o[0]), .adr_inc(adr_inc), .cnt_dec(cnt_dec),
    .addr_out(adr_o[0]), .cnt_zero(cz_o[0]));

  lane_regfile #(.WIDTH(16), .DEPTH(8), .LANE_W(4), .ADR_IDX(4), .CNT_IDX(7),
                 .ADR_STEP(1), .BYPASS(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_lane_mask(wr_lane_mask), .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
    .rd0_imm(rd0_imm), .rd1_zero(rd1_zero), .rd_data0(rd0_o[1]), .rd_data1(rd1_o[1]),
    .st_addr(st_addr), .st_data(st_o[1]), .adr_inc(adr_inc), .cnt_dec(cnt_dec),
    .addr_out(adr_o[1]), .cnt_zero(cz_o[1]));

  lane_regfile #(.WIDTH(16), .DEPTH(6), .LANE_W(4), .ADR_IDX(4), .CNT_IDX(5),
                 .ADR_STEP(1), .BYPASS(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_lane_mask(wr_lane_mask), .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
    .rd0_imm(rd0_imm), .rd1_zero(rd1_zero), .rd_data0(rd0_o[2]), .rd_data1(rd1_o[2]),
    .st_addr(st_addr), .st_data(st_o[2]), .adr_inc(adr_inc), .cnt_dec(cnt_dec),
    .addr_out(adr_o[2]), .cnt_zero(cz_o[2]));

  // Value a register holds after a write of wr_data under wr_lane_mask.
  function automatic logic [15:0] written(input logic [15:0] old);
    logic [15:0] keep = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      if (wr_lane_mask[i]) keep = keep | (16'hF << (4 * i));
    end
    return (old & ~keep) | (wr_data & keep);
  endfunction

  function automatic logic [15:0] exp_read(input int c, input logic [2:0] a);
    if (int'(a) >= depth_c[c]) return 16'h0000;
    if (byp_c[c] != 0 && wr_en && a == wr_addr) return written(mdl[c][a]);
    return mdl[c][a];
  endfunction

  task automatic model_update();
    for (int c = 0; c < 3; c++) begin
      logic [15:0] nxt [8];
      logic        wr_ok;
      for (int k = 0; k < 8; k++) nxt[k] = rst_n ? mdl[c][k] : 16'h0000;
      if (rst_n) begin
        wr_ok = wr_en && (int'(wr_addr) < depth_c[c]) && (wr_lane_mask != 4'h0);
        if (adr_inc && !(wr_ok && int'(wr_addr) == adr_c[c]))
          nxt[adr_c[c]] = mdl[c][adr_c[c]] + 16'd1;
        if (cnt_dec && !(wr_ok && int'(wr_addr) == cnt_c[c]) && mdl[c][cnt_c[c]] != 16'h0000)
          nxt[cnt_c[c]] = mdl[c][cnt_c[c]] - 16'd1;
        if (wr_ok) nxt[wr_addr] = written(mdl[c][wr_addr]);
      end
      for (int k = 0; k < 8; k++) mdl[c][k] = nxt[k];
    end
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst_n = 1'b1; wr_en = 1'b0; wr_addr = 3'd0; wr_data = 16'h0000; wr_lane_mask = 4'hF;
    rd_addr0 = 3'd0; rd_addr1 = 3'd0; st_addr = 3'd0;
    rd0_imm = 1'b0; rd1_zero = 1'b0; adr_inc = 1'b0; cnt_dec = 1'b0;
  endtask

  task automatic test_reset();
    idle(); rst_n = 1'b0;
    tick();
    idle(); rd_addr0 = 3'd2; #1;
    total++; if (adr_o[0] !== 16'h0000) begin bad++; $display("FAIL reset_addr_out got=%h exp=0000", adr_o[0]); end
    total++; if (cz_o[0] !== 1'b1) begin bad++; $display("FAIL reset_cnt_zero got=%b exp=1", cz_o[0]); end
    total++; if (rd0_o[0] !== 16'h0000) begin bad++; $display("FAIL reset_rd_r2 got=%h exp=0000", rd0_o[0]); end
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'hBEEF;
    tick();
    idle(); rd_addr0 = 3'd2; #1;
    total++; if (rd0_o[0] !== 16'hBEEF) begin bad++; $display("FAIL full_write_r2 got=%h exp=BEEF", rd0_o[0]); end
    rst_n = 1'b0; wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h1111; cnt_dec = 1'b1;
    tick();
    idle(); rd_addr0 = 3'd2; #1;
    total++; if (rd0_o[0] !== 16'h0000) begin bad++; $display("FAIL reset_over_write got=%h exp=0000", rd0_o[0]); end
    total++; if (cz_o[0] !== 1'b1) begin bad++; $display("FAIL reset_over_write_cz got=%b exp=1", cz_o[0]); end
  endtask

  task automatic test_lane_mask();
    idle(); wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'h1234;
    tick();
    wr_data = 16'h00A0; wr_lane_mask = 4'b0010;
    tick();
    idle(); rd_addr1 = 3'd1; #1;
    total++; if (rd1_o[0] !== 16'h12A4) begin bad++; $display("FAIL lane_write got=%h exp=12A4", rd1_o[1 - 1]); end
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'hFFFF; wr_lane_mask = 4'h0;
    tick();
    idle(); rd_addr1 = 3'd1; #1;
    total++; if (rd1_o[0] !== 16'h12A4) begin bad++; $display("FAIL mask_zero got=%h exp=12A4", rd1_o[0]); end
  endtask

  task automatic test_bypass();
    idle(); wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'h1111;
    tick();
    wr_data = 16'h5555; rd_addr0 = 3'd3; rd_addr1 = 3'd3; st_addr = 3'd3; #1;
    total++; if (rd0_o[0] !== 16'h5555) begin bad++; $display("FAIL bypass_rd0 got=%h exp=5555", rd0_o[0]); end
    total++; if (rd1_o[0] !== 16'h5555) begin bad++; $display("FAIL bypass_rd1 got=%h exp=5555", rd1_o[0]); end
    total++; if (st_o[0] !== 16'h5555) begin bad++; $display("FAIL bypass_st got=%h exp=5555", st_o[0]); end
    total++; if (rd0_o[1] !== 16'h1111) begin bad++; $display("FAIL nobypass_rd0 got=%h exp=1111", rd0_o[1]); end
    total++; if (st_o[1] !== 16'h1111) begin bad++; $display("FAIL nobypass_st got=%h exp=1111", st_o[1]); end
    tick();
    wr_en = 1'b0; #1;
    total++; if (rd1_o[1] !== 16'h5555) begin bad++; $display("FAIL nobypass_next got=%h exp=5555", rd1_o[1]); end
  endtask

  task automatic test_adr();
    idle(); wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'hFFFF;
    tick();
    idle(); adr_inc = 1'b1; #1;
    total++; if (adr_o[0] !== 16'hFFFF) begin bad++; $display("FAIL adr_preset got=%h exp=FFFF", adr_o[0]); end
    tick();
    total++; if (adr_o[0] !== 16'h0000) begin bad++; $display("FAIL adr_wrap got=%h exp=0000", adr_o[0]); end
    wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'h0100;
    tick();
    idle(); #1;
    total++; if (adr_o[0] !== 16'h0100) begin bad++; $display("FAIL adr_collision got=%h exp=0100", adr_o[0]); end
  endtask

  task automatic test_cnt();
    logic [15:0] exp_v [3] = '{16'd1, 16'd0, 16'd0};
    idle(); wr_en = 1'b1; wr_addr = 3'd7; wr_data = 16'd2;
    tick();
    idle(); rd_addr0 = 3'd7; #1;
    total++; if (cz_o[0] !== 1'b0) begin bad++; $display("FAIL cnt_loaded_cz got=%b exp=0", cz_o[0]); end
    cnt_dec = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (rd0_o[0] !== exp_v[i]) begin bad++; $display("FAIL cnt_dec_%0d got=%h exp=%h", i, rd0_o[0], exp_v[i]); end
      total++; if (cz_o[0] !== (i != 0)) begin bad++; $display("FAIL cnt_zero_%0d got=%b exp=%b", i, cz_o[0], i != 0); end
    end
  endtask

  task automatic test_imm_zero();
    idle(); rd0_imm = 1'b1; rd_addr0 = 3'd5; rd1_zero = 1'b1; rd_addr1 = 3'd1; #1;
    total++; if (rd0_o[0] !== 16'h0005) begin bad++; $display("FAIL imm_rd0 got=%h exp=0005", rd0_o[0]); end
    total++; if (rd1_o[0] !== 16'h0000) begin bad++; $display("FAIL zero_rd1 got=%h exp=0000", rd1_o[0]); end
  endtask

  task automatic test_out_of_range();
    idle(); wr_en = 1'b1; wr_addr = 3'd7; wr_data = 16'hABCD; rd_addr0 = 3'd7; st_addr = 3'd7; #1;
    total++; if (rd0_o[2] !== 16'h0000) begin bad++; $display("FAIL oor_bypass got=%h exp=0000", rd0_o[2]); end
    tick();
    idle(); rd_addr0 = 3'd7; rd_addr1 = 3'd6; st_addr = 3'd7; #1;
    total++; if (rd0_o[2] !== 16'h0000) begin bad++; $display("FAIL oor_read7 got=%h exp=0000", rd0_o[2]); end
    total++; if (rd1_o[2] !== 16'h0000) begin bad++; $display("FAIL oor_read6 got=%h exp=0000", rd1_o[2]); end
    total++; if (st_o[2] !== 16'h0000) begin bad++; $display("FAIL oor_st got=%h exp=0000", st_o[2]); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rst_n        = ($urandom_range(0, 39) != 0);
      wr_en        = $urandom_range(0, 1);
      wr_addr      = 3'($urandom);
      wr_data      = 16'($urandom);
      wr_lane_mask = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom);
      rd_addr0     = 3'($urandom);
      rd_addr1     = 3'($urandom);
      st_addr      = 3'($urandom);
      rd0_imm      = ($urandom_range(0, 7) == 0);
      rd1_zero     = ($urandom_range(0, 7) == 0);
      adr_inc      = $urandom_range(0, 1);
      cnt_dec      = ($urandom_range(0, 3) != 0);
      #1;
      for (int c = 0; c < 3; c++) begin
        logic [15:0] e0, e1, es;
        e0 = rd0_imm ? {13'd0, rd_addr0} : exp_read(c, rd_addr0);
        e1 = rd1_zero ? 16'h0000 : exp_read(c, rd_addr1);
        es = exp_read(c, st_addr);
        total++; if (rd0_o[c] !== e0) begin bad++; $display("FAIL rand_rd0 cfg=%0d cyc=%0d got=%h exp=%h", c, n, rd0_o[c], e0); end
        total++; if (rd1_o[c] !== e1) begin bad++; $display("FAIL rand_rd1 cfg=%0d cyc=%0d got=%h exp=%h", c, n, rd1_o[c], e1); end
        total++; if (st_o[c] !== es) begin bad++; $display("FAIL rand_st cfg=%0d cyc=%0d got=%h exp=%h", c, n, st_o[c], es); end
        total++; if (adr_o[c] !== mdl[c][adr_c[c]]) begin bad++; $display("FAIL rand_addr cfg=%0d cyc=%0d got=%h exp=%h", c, n, adr_o[c], mdl[c][adr_c[c]]); end
        total++; if (cz_o[c] !== (mdl[c][cnt_c[c]] == 16'h0000)) begin bad++; $display("FAIL rand_cz cfg=%0d cyc=%0d got=%b exp=%b", c, n, cz_o[c], mdl[c][cnt_c[c]] == 16'h0000); end
      end
      tick();
    end
  endtask

  initial begin
    for (int c = 0; c < 3; c++)
      for (int k = 0; k < 8; k++) mdl[c][k] = 16'h0000;
    idle();
    test_reset();
    test_lane_mask();
    test_bypass();
    test_adr();
    test_cnt();
    test_imm_zero();
    test_out_of_range();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
